// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch unit.
// FSM state encoding, branch-target LUT depth and the default target table.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int LUT_DEPTH = 4;
    localparam int LUT_AW    = $clog2(LUT_DEPTH);
    localparam int PW_DEF    = 10;

    // Default jump/branch targets, indexed by TargSel.
    localparam logic [PW_DEF-1:0] TARGET_TABLE [LUT_DEPTH] = '{
        10'h000, 10'h010, 10'h020, 10'h030
    };

endpackage

// File: rtl/fetch_unit_target_lut.sv
// target_lut: combinational map from the decoder's TargSel index to a
// branch/jump target address, resized to the program-counter width.
module target_lut
    import fetch_pkg::*;
#(
    parameter int PW = 10
) (
    input  logic [LUT_AW-1:0] sel,
    output logic [PW-1:0]     targ
);

    assign targ = PW'(TARGET_TABLE[sel]);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencer with IDLE/RUN/HALT control.
// Optional feature: define FETCH_INSTR_COUNT_EN to add the 16-bit
// saturating InstrCount output counting RUN cycles.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PW = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Jump,
    input  logic          BranchEn,
    input  logic          Zero,
    input  logic [1:0]    TargSel,
    input  logic          Ack,
    output logic [PW-1:0] ProgCtr,
    output logic          Running,
    output logic          Done
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [15:0]   InstrCount
`endif
);

    state_t        state;
    logic [PW-1:0] targ;
    logic          redirect;

    target_lut #(.PW(PW)) u_lut (
        .sel  (TargSel),
        .targ (targ)
    );

    // Taken branch or jump loads the LUT target on the next edge (no delay slot).
    assign redirect = Jump | (BranchEn & Zero);

    // Control FSM and program counter; Start wins in every state, Ack beats redirects.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
            Running <= 1'b0;
            Done    <= 1'b0;
        end else if (Start) begin
            state   <= RUN;
            ProgCtr <= StartAddr;
            Running <= 1'b1;
            Done    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (Ack) begin
                        state   <= HALT;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else if (redirect) begin
                        ProgCtr <= targ;
                    end else begin
                        ProgCtr <= ProgCtr + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_INSTR_COUNT_EN
    // RUN-cycle counter: clears on Start, saturates, frozen outside RUN.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            InstrCount <= '0;
        end else if (Start) begin
            InstrCount <= '0;
        end else if (state == RUN && InstrCount != 16'hFFFF) begin
            InstrCount <= InstrCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Each driven cycle pushes the
// expected post-edge outputs from a small behavioural model; they are popped
// and compared one time unit after the rising edge.
module tb_fetch_unit;

    localparam int PW = 10;

    typedef struct {
        logic [PW-1:0] pc;
        logic          run;
        logic          done;
        logic [15:0]   cnt;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [PW-1:0] StartAddr;
    logic          Jump;
    logic          BranchEn;
    logic          Zero;
    logic [1:0]    TargSel;
    logic          Ack;
    logic [PW-1:0] ProgCtr;
    logic          Running;
    logic          Done;
`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0]   InstrCount;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // Model state: 0 idle, 1 run, 2 halt
    int            m_st;
    logic [PW-1:0] m_pc;
    logic [15:0]   m_cnt;
    logic [PW-1:0] tbl [4];

    fetch_unit #(.PW(PW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Jump      (Jump),
        .BranchEn  (BranchEn),
        .Zero      (Zero),
        .TargSel   (TargSel),
        .Ack       (Ack),
        .ProgCtr   (ProgCtr),
        .Running   (Running),
        .Done      (Done)
`ifdef FETCH_INSTR_COUNT_EN
        ,
        .InstrCount(InstrCount)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_pc  = '0;
        m_cnt = '0;
    endtask

    // Drive one cycle of inputs, predict, clock, then pop and compare.
    task automatic cyc(input logic st, input logic [PW-1:0] sa, input logic j,
                       input logic br, input logic z, input logic [1:0] ts,
                       input logic ak);
        exp_t e;
        @(negedge Clk);
        Start = st; StartAddr = sa; Jump = j; BranchEn = br; Zero = z;
        TargSel = ts; Ack = ak;
        if (st) begin
            m_st = 1; m_pc = sa; m_cnt = '0;
        end else if (m_st == 1) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (ak)                m_st = 2;
            else if (j || (br && z)) m_pc = tbl[ts];
            else                   m_pc = m_pc + 1'b1;
        end
        e.pc = m_pc; e.run = (m_st == 1); e.done = (m_st == 2); e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("ProgCtr", 32'(ProgCtr), 32'(e.pc));
            chk("Running", 32'(Running), 32'(e.run));
            chk("Done",    32'(Done),    32'(e.done));
`ifdef FETCH_INSTR_COUNT_EN
            chk("InstrCount", 32'(InstrCount), 32'(e.cnt));
`endif
        end
    endtask

    task automatic idle_cyc();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},   32'(ProgCtr), 32'd0);
        chk({tag, "_run"},  32'(Running), 32'd0);
        chk({tag, "_done"}, 32'(Done),    32'd0);
`ifdef FETCH_INSTR_COUNT_EN
        chk({tag, "_cnt"},  32'(InstrCount), 32'd0);
`endif
    endtask

    initial begin
        tbl[0] = 10'h000; tbl[1] = 10'h010; tbl[2] = 10'h020; tbl[3] = 10'h030;
        Start = 0; StartAddr = '0; Jump = 0; BranchEn = 0; Zero = 0; TargSel = 0; Ack = 0;
        Reset = 1'b0;
        model_reset();
        #12;
        chk_reset_state("reset");
        @(negedge Clk);
        Reset = 1'b1;

        // Control inputs ignored in IDLE
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
        idle_cyc();

        // Start at 0x005, sequential fetch
        cyc(1'b1, 10'h005, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle_cyc();
        idle_cyc();
        idle_cyc();                                         // 0x008
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);        // jump -> 0x020
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);        // not taken -> 0x021
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);        // taken -> 0x010
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);        // jump -> 0x030
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);        // Zero alone -> inc

        // Wrap at all-ones (restart while running)
        cyc(1'b1, 10'h3FE, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle_cyc();                                         // 0x3FF
        idle_cyc();                                         // 0x000
        idle_cyc();

        // Ack overrides Jump, HALT holds, Start restarts
        cyc(1'b1, 10'h012, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
        idle_cyc();
        cyc(1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle_cyc();

        // Mid-RUN asynchronous reset at 0x0A0
        cyc(1'b1, 10'h09E, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle_cyc();
        idle_cyc();                                         // 0x0A0
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk_reset_state("midrun_reset");
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        idle_cyc();
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        idle_cyc();

        // Start, 3 RUN cycles, Ack -> 4 counted RUN cycles
        cyc(1'b1, 10'h005, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        idle_cyc();
        idle_cyc();
        cyc(1'b1, 10'h200, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(0, 15) == 0), 10'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
